// File: rtl/fifo_cover_monitor.sv
// Passive ready/valid FIFO monitor: shadow queue, data and handshake
// checking, per-occupancy coverage bins and saturating counters.
`timescale 1ns/1ps
module fifo_cover_monitor #(
  parameter int WIDTH           = 8,
  parameter int DEPTH           = 8,
  parameter int ALLOW_FULL_BOTH = 0,
  parameter int COUNT_W         = 16
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       clear_i,
  input  logic                       enq_valid_i,
  input  logic                       enq_ready_i,
  input  logic [WIDTH-1:0]           enq_data_i,
  input  logic                       deq_valid_i,
  input  logic                       deq_yumi_i,
  input  logic [WIDTH-1:0]           deq_data_i,
  output logic [$clog2(DEPTH+1)-1:0] occupancy_o,
  output logic [DEPTH:0]             cover_enq_o,
  output logic [DEPTH:0]             cover_deq_o,
  output logic [DEPTH:0]             cover_both_o,
  output logic                       cover_full_o,
  output logic [COUNT_W-1:0]         enq_count_o,
  output logic [COUNT_W-1:0]         deq_count_o,
  output logic                       err_o,
  output logic [2:0]                 err_code_o
);

  localparam int OW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [OW-1:0] FULL = OW'(DEPTH);
  localparam logic [OW-1:0] LOW  = OW'(DEPTH-1);

  localparam logic [DEPTH:0] ENQ_MASK =
    {1'b0, {DEPTH{1'b1}}};
  localparam logic [DEPTH:0] DEQ_MASK =
    {{DEPTH{1'b1}}, 1'b0};
  localparam logic [DEPTH:0] BOTH_MASK =
    {(ALLOW_FULL_BOTH != 0), {(DEPTH-1){1'b1}}, 1'b0};

  typedef enum logic [2:0] {
    E_NONE = 3'd0,
    E_OVF  = 3'd1,
    E_UNF  = 3'd2,
    E_DATA = 3'd3,
    E_RDY  = 3'd4
  } err_e;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    head, tail;

  logic enq, deq, is_empty, is_full;
  logic unf, ovf, dat, rdy, push, pop;
  err_e code_now;

  logic [DEPTH:0]   cov_enq_n, cov_deq_n, cov_both_n;
  logic [COUNT_W-1:0] enq_cnt_n, deq_cnt_n;
  logic             err_n, full_n;
  logic [2:0]       code_n;

  always_comb begin
    enq      = enq_valid_i & enq_ready_i;
    deq      = deq_valid_i & deq_yumi_i;
    is_empty = (occupancy_o == '0);
    is_full  = (occupancy_o == FULL);
    unf      = deq_valid_i & is_empty;
    ovf      = enq & is_full
             & ~(deq & (ALLOW_FULL_BOTH != 0));
    dat      = deq & ~is_empty
             & (deq_data_i != mem[head]);
    rdy      = ~enq_ready_i & (occupancy_o < LOW);
    // illegal events never touch the shadow queue
    push     = enq & ~ovf;
    pop      = deq & ~is_empty;
  end

  always_comb begin
    if (unf)      code_now = E_UNF;
    else if (ovf) code_now = E_OVF;
    else if (dat) code_now = E_DATA;
    else if (rdy) code_now = E_RDY;
    else          code_now = E_NONE;
  end

  always_comb begin
    cov_enq_n  = cover_enq_o;
    cov_deq_n  = cover_deq_o;
    cov_both_n = cover_both_o;
    enq_cnt_n  = enq_count_o;
    deq_cnt_n  = deq_count_o;
    err_n      = err_o;
    code_n     = err_code_o;
    if (clear_i) begin
      cov_enq_n  = '0;
      cov_deq_n  = '0;
      cov_both_n = '0;
      enq_cnt_n  = '0;
      deq_cnt_n  = '0;
      err_n      = 1'b0;
      code_n     = E_NONE;
    end else begin
      unique case ({enq, deq})
        2'b10:   cov_enq_n[occupancy_o]  = 1'b1;
        2'b01:   cov_deq_n[occupancy_o]  = 1'b1;
        2'b11:   cov_both_n[occupancy_o] = 1'b1;
        default: ;
      endcase
      if (push && enq_count_o != '1)
        enq_cnt_n = enq_count_o + COUNT_W'(1);
      if (pop && deq_count_o != '1)
        deq_cnt_n = deq_count_o + COUNT_W'(1);
      if (!err_o && code_now != E_NONE) begin
        err_n  = 1'b1;
        code_n = code_now;
      end
    end
  end

  always_comb begin
    full_n = (&(cov_enq_n  | ~ENQ_MASK))
           & (&(cov_deq_n  | ~DEQ_MASK))
           & (&(cov_both_n | ~BOTH_MASK));
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      occupancy_o  <= '0;
      head         <= '0;
      tail         <= '0;
      cover_enq_o  <= '0;
      cover_deq_o  <= '0;
      cover_both_o <= '0;
      cover_full_o <= 1'b0;
      enq_count_o  <= '0;
      deq_count_o  <= '0;
      err_o        <= 1'b0;
      err_code_o   <= E_NONE;
    end else begin
      occupancy_o  <= occupancy_o + OW'(push)
                    - OW'(pop);
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      cover_enq_o  <= cov_enq_n;
      cover_deq_o  <= cov_deq_n;
      cover_both_o <= cov_both_n;
      cover_full_o <= full_n;
      enq_count_o  <= enq_cnt_n;
      deq_count_o  <= deq_cnt_n;
      err_o        <= err_n;
      err_code_o   <= code_n;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[tail] <= enq_data_i;
  end

endmodule

// File: tb/tb_fifo_cover_monitor.sv
// Bench for fifo_cover_monitor: two instances (full pass-through off/on)
// checked every cycle against a queue-level model plus literal values.
`timescale 1ns/1ps
module tb_fifo_cover_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr = 1'b0;
  logic       ev = 1'b0, er = 1'b1;
  logic       dv = 1'b0, dy = 1'b0;
  logic [7:0] ed = '0, dd = '0;
  bit         run = 1'b0;

  logic [3:0]  occ   [2];
  logic [8:0]  cen   [2];
  logic [8:0]  cdq   [2];
  logic [8:0]  cbo   [2];
  logic        cfull [2];
  logic [15:0] ecnt  [2];
  logic [15:0] dcnt  [2];
  logic        err   [2];
  logic [2:0]  code  [2];

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  fifo_cover_monitor #(
    .WIDTH(8), .DEPTH(8),
    .ALLOW_FULL_BOTH(0), .COUNT_W(16)
  ) u0 (
    .clk_i(clk), .reset_i(rst), .clear_i(clr),
    .enq_valid_i(ev), .enq_ready_i(er),
    .enq_data_i(ed), .deq_valid_i(dv),
    .deq_yumi_i(dy), .deq_data_i(dd),
    .occupancy_o(occ[0]), .cover_enq_o(cen[0]),
    .cover_deq_o(cdq[0]), .cover_both_o(cbo[0]),
    .cover_full_o(cfull[0]),
    .enq_count_o(ecnt[0]), .deq_count_o(dcnt[0]),
    .err_o(err[0]), .err_code_o(code[0])
  );

  fifo_cover_monitor #(
    .WIDTH(8), .DEPTH(8),
    .ALLOW_FULL_BOTH(1), .COUNT_W(16)
  ) u1 (
    .clk_i(clk), .reset_i(rst), .clear_i(clr),
    .enq_valid_i(ev), .enq_ready_i(er),
    .enq_data_i(ed), .deq_valid_i(dv),
    .deq_yumi_i(dy), .deq_data_i(dd),
    .occupancy_o(occ[1]), .cover_enq_o(cen[1]),
    .cover_deq_o(cdq[1]), .cover_both_o(cbo[1]),
    .cover_full_o(cfull[1]),
    .enq_count_o(ecnt[1]), .deq_count_o(dcnt[1]),
    .err_o(err[1]), .err_code_o(code[1])
  );

  // model: instance i allows full pass-through iff i==1
  logic [7:0] mq   [2][9];
  int         msz  [2];
  logic [8:0] mcen [2];
  logic [8:0] mcdq [2];
  logic [8:0] mcbo [2];
  int         mec  [2];
  int         mdc  [2];
  bit         merr [2];
  int         mcode[2];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        msz[i] = 0; mcen[i] = '0;
        mcdq[i] = '0; mcbo[i] = '0;
        mec[i] = 0; mdc[i] = 0;
        merr[i] = 0; mcode[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        int o, c;
        bit e, d, uf, of, dt, rd;
        o  = msz[i];
        e  = ev && er;
        d  = dv && dy;
        uf = dv && o == 0;
        of = e && o == 8 && !(d && i == 1);
        dt = d && o > 0 && dd != mq[i][0];
        rd = !er && o < 7;
        c  = uf ? 2 : of ? 1 : dt ? 3 : rd ? 4 : 0;
        if (d && o > 0) begin
          for (int k = 0; k < 8; k++)
            mq[i][k] = mq[i][k+1];
          msz[i]--;
          if (!clr && mdc[i] < 65535) mdc[i]++;
        end
        if (e && !of) begin
          mq[i][msz[i]] = ed;
          msz[i]++;
          if (!clr && mec[i] < 65535) mec[i]++;
        end
        if (clr) begin
          mcen[i] = '0; mcdq[i] = '0; mcbo[i] = '0;
          mec[i] = 0; mdc[i] = 0;
          merr[i] = 0; mcode[i] = 0;
        end else begin
          if (e && !d) mcen[i][o] = 1'b1;
          if (d && !e) mcdq[i][o] = 1'b1;
          if (d && e)  mcbo[i][o] = 1'b1;
          if (!merr[i] && c != 0) begin
            merr[i] = 1; mcode[i] = c;
          end
        end
      end
    end
  end

  function automatic bit exp_full(input int i);
    bit r = 1;
    for (int k = 0; k < 8; k++) r &= mcen[i][k];
    for (int k = 1; k < 9; k++) r &= mcdq[i][k];
    for (int k = 1; k < 8; k++) r &= mcbo[i][k];
    if (i == 1) r &= mcbo[i][8];
    return r;
  endfunction

  task automatic chk(input string nm, input int i,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s[u%0d] got %0h expected %0h",
                  nm, i, act, exp);
  endtask

  always @(negedge clk) begin
    if (run) begin
      for (int i = 0; i < 2; i++) begin
        chk("occ", i, 32'(occ[i]), 32'(msz[i]));
        chk("cov_enq", i, 32'(cen[i]), 32'(mcen[i]));
        chk("cov_deq", i, 32'(cdq[i]), 32'(mcdq[i]));
        chk("cov_both", i, 32'(cbo[i]), 32'(mcbo[i]));
        chk("cov_full", i, 32'(cfull[i]),
            32'(exp_full(i)));
        chk("enq_cnt", i, 32'(ecnt[i]), 32'(mec[i]));
        chk("deq_cnt", i, 32'(dcnt[i]), 32'(mdc[i]));
        chk("err", i, 32'(err[i]), 32'(merr[i]));
        chk("code", i, 32'(code[i]), 32'(mcode[i]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    ev = 0; er = 1; dv = 0; dy = 0; clr = 0;
  endtask

  task automatic enq(input logic [7:0] x);
    ev = 1; ed = x; tick();
  endtask

  task automatic deq(input logic [7:0] x);
    dv = 1; dy = 1; dd = x; tick();
  endtask

  task automatic both(input logic [7:0] x,
                      input logic [7:0] y);
    ev = 1; ed = x; dv = 1; dy = 1; dd = y; tick();
  endtask

  task automatic clear();
    clr = 1; tick();
  endtask

  task automatic reset();
    rst = 1; #3; rst = 0;
  endtask

  initial begin
    #1 rst = 1;
    #10 rst = 0;
    run = 1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_occ", i, 32'(occ[i]), 0);
      chk("rst_cov", i, 32'(cen[i] | cdq[i] | cbo[i]), 0);
      chk("rst_cnt", i, 32'(ecnt[i] | dcnt[i]), 0);
      chk("rst_err", i, 32'({err[i], code[i]}), 0);
    end

    for (int k = 0; k < 8; k++) enq(8'h10 + 8'(k));
    for (int i = 0; i < 2; i++) begin
      chk("fill_occ", i, 32'(occ[i]), 8);
      chk("fill_cov", i, 32'(cen[i]), 32'h0FF);
      chk("fill_cnt", i, 32'(ecnt[i]), 8);
      chk("fill_err", i, 32'(err[i]), 0);
    end

    for (int k = 0; k < 8; k++) deq(8'h10 + 8'(k));
    for (int i = 0; i < 2; i++) begin
      chk("drain_occ", i, 32'(occ[i]), 0);
      chk("drain_cov", i, 32'(cdq[i]), 32'h1FE);
      chk("drain_cnt", i, 32'(dcnt[i]), 8);
      chk("drain_err", i, 32'(err[i]), 0);
    end

    for (int k = 0; k < 8; k++) enq(8'h20 + 8'(k));
    deq(8'h20); deq(8'h21); deq(8'h99);
    for (int i = 0; i < 2; i++)
      chk("data_code", i, 32'(code[i]), 3);
    for (int k = 3; k < 8; k++) deq(8'h20 + 8'(k));
    dv = 1; tick();
    for (int i = 0; i < 2; i++)
      chk("sticky_code", i, 32'(code[i]), 3);
    clear();
    for (int i = 0; i < 2; i++)
      chk("clr_err", i, 32'({err[i], code[i]}), 0);

    for (int k = 0; k < 8; k++) enq(8'h30 + 8'(k));
    enq(8'h40);
    for (int i = 0; i < 2; i++) begin
      chk("ovf_code", i, 32'(code[i]), 1);
      chk("ovf_occ", i, 32'(occ[i]), 8);
    end
    clear();
    both(8'h41, 8'h30);
    chk("fb_code", 0, 32'(code[0]), 1);
    chk("fb_occ", 0, 32'(occ[0]), 7);
    chk("fb_err", 1, 32'(err[1]), 0);
    chk("fb_cov", 1, 32'(cbo[1]), 32'h100);
    chk("fb_occ", 1, 32'(occ[1]), 8);
    reset();

    dv = 1; tick();
    for (int i = 0; i < 2; i++)
      chk("unf_code", i, 32'(code[i]), 2);
    clear();
    dv = 1; er = 0; tick();
    for (int i = 0; i < 2; i++)
      chk("prio_code", i, 32'(code[i]), 2);
    enq(8'h50); enq(8'h51);
    clear();
    for (int i = 0; i < 2; i++) begin
      chk("keep_err", i, 32'(err[i]), 0);
      chk("keep_occ", i, 32'(occ[i]), 2);
    end
    reset();

    for (int k = 0; k < 8; k++) begin
      enq(8'h60 + 8'(k));
      if (k < 7) both(8'h70 + 8'(k), mq[1][0]);
    end
    for (int k = 0; k < 8; k++) deq(mq[1][0]);
    for (int k = 0; k < 8; k++) enq(8'h80 + 8'(k));
    chk("sweep_full", 0, 32'(cfull[0]), 1);
    chk("sweep_full", 1, 32'(cfull[1]), 0);
    both(8'h90, mq[1][0]);
    chk("sweep_both", 0, 32'(cfull[0]), 1);
    chk("sweep_both", 1, 32'(cfull[1]), 1);
    rst = 1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("mid_occ", i, 32'(occ[i]), 0);
      chk("mid_cov", i, 32'(cen[i] | cdq[i] | cbo[i]), 0);
      chk("mid_full", i, 32'(cfull[i]), 0);
      chk("mid_cnt", i, 32'(ecnt[i] | dcnt[i]), 0);
      chk("mid_err", i, 32'({err[i], code[i]}), 0);
    end
    #2 rst = 0;
    tick(); tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
